// File: rtl/ph_block_avg.sv
// Block averager of 2^lg phase samples on the circle, referenced to each block's first sample.
// Build option: define PH_BLOCK_AVG_ROUND_EN to round the mean half up instead of flooring it.
module ph_block_avg #(
  parameter int w  = 16,
  parameter int lg = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [w-1:0] ph_in,
  input  logic         ph_valid,
  output logic [w-1:0] ph_out,
  output logic         out_valid,
  output logic         warn,
  output logic         busy
);

  // Handshake: ph_valid has no back-pressure; a sample is taken on every edge where it is high.
  // out_valid is a one-cycle strobe with no ready; ph_out and warn hold until the next block end.
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic [lg-1:0] cnt_last = '1;

  state_t          state, state_next;
  logic [w-1:0]    ref_ph;
  logic [w+lg-1:0] acc, acc_next;
  logic [lg-1:0]   cnt;
  logic            sticky, sticky_next;
  logic [w-1:0]    d, mean_off, ph_next;
  logic            start, take, done, abort;

  // Offsets wrap at w bits so blocks straddling +/- half a turn stay contiguous.
  assign d           = ph_in - ref_ph;
  assign acc_next    = acc + {{lg{d[w-1]}}, d};
  assign sticky_next = sticky | (d[w-1] ^ d[w-2]);

`ifdef PH_BLOCK_AVG_ROUND_EN
  // Adding 2^(lg-1) before the shift only carries into the quotient when bit lg-1 is set.
  assign mean_off = acc_next[w+lg-1:lg] + {{(w-1){1'b0}}, acc_next[lg-1]};
`else
  assign mean_off = acc_next[w+lg-1:lg];
`endif

  assign ph_next = ref_ph + mean_off;
  assign busy    = (state == ACC);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    take       = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ph_valid) begin
          start      = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (clear) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (ph_valid) begin
          take = 1'b1;
          if (cnt == cnt_last) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_ph    <= '0;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      ph_out    <= '0;
      warn      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= done;
      if (start) begin
        ref_ph <= ph_in;
        acc    <= '0;
        cnt    <= lg'(1);
        sticky <= 1'b0;
      end else if (abort) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end else if (take) begin
        acc    <= acc_next;
        cnt    <= cnt + lg'(1);
        sticky <= sticky_next;
      end
      if (done) begin
        ph_out <= ph_next;
        warn   <= sticky_next;
      end
    end
  end

endmodule

// File: tb/tb_ph_block_avg.sv
// Bench for ph_block_avg: scenario tasks plus a scoreboard of expected {warn, ph_out} per block.
module tb_ph_block_avg;
  localparam int w  = 16;
  localparam int lg = 2;

  logic         clk = 1'b0;
  logic         rst_n, clear, ph_valid;
  logic [w-1:0] ph_in, ph_out;
  logic         out_valid, warn, busy;

  logic [w:0] exp_q[$];
  logic [w:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;

  ph_block_avg #(.w(w), .lg(lg)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ph_in(ph_in), .ph_valid(ph_valid),
    .ph_out(ph_out), .out_valid(out_valid), .warn(warn), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_out: out_valid=1 ph_out=%0d warn=%b with no block pending",
                 $signed(ph_out), warn);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({warn, ph_out} !== mon_exp)
          $display("FAIL block_result: got ph_out=%0d warn=%b, expected ph_out=%0d warn=%b",
                   $signed(ph_out), warn, $signed(mon_exp[w-1:0]), mon_exp[w]);
        else
          n_pass++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [w-1:0] s);
    ph_in    = s;
    ph_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ph_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    ph_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: floor (or round-half-up) mean of wrapped offsets from the first sample.
  function automatic logic [w:0] model(input logic [w-1:0] s0, s1, s2, s3);
    logic [w-1:0]        smp [4];
    logic signed [w-1:0] dd;
    int                  di, sum, mean;
    logic                wr;
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    sum = 0;
    wr  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dd = smp[i] - s0;
      di = dd;
      if (di >= 16384 || di < -16384) wr = 1'b1;
      sum += di;
    end
`ifdef PH_BLOCK_AVG_ROUND_EN
    sum += 2;
`endif
    if (sum >= 0) mean = sum / 4;
    else          mean = -((-sum + 3) / 4);
    return {wr, s0 + w'(mean)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; ph_valid = 1'b0; ph_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ph_out !== '0)    $display("FAIL rst_ph_out: got %0d expected 0", ph_out);  else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (warn !== 1'b0)    $display("FAIL rst_warn: got %b expected 0", warn);        else n_pass++;
    n_checks++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %b expected 0", busy);        else n_pass++;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    send(16'd100);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy1: got %b expected 1", busy); else n_pass++;
    send(16'd102);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy2: got %b expected 1", busy); else n_pass++;
    send(16'd104);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy3: got %b expected 1", busy); else n_pass++;
    exp_q.push_back({1'b0, 16'd103});
    send(16'd106);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%b expected 1", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy); else n_pass++;
    idle(1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_strobe_len: out_valid=%b expected 0", out_valid); else n_pass++;
    n_checks++; if (ph_out !== 16'd103) $display("FAIL basic_hold: ph_out=%0d expected 103", ph_out); else n_pass++;
  endtask

  task automatic test_wrap();
    send(16'h7FFE);
    send(16'h8002);
    send(16'h7FFF);
    exp_q.push_back({1'b0, 16'h8000});
    send(16'h8001);
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL wrap_drain: %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    send(16'd0);
    send(16'd16384);
    send(16'd0);
    exp_q.push_back({1'b1, 16'd4096});
    send(16'd0);
    send(16'd5);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_no_dead_cycle: busy=%b expected 1", busy); else n_pass++;
    send(16'd5);
    send(16'd5);
    exp_q.push_back({1'b0, 16'd5});
    send(16'd5);
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_rounding();
    send(16'd100);
    send(16'd101);
    send(16'd101);
`ifdef PH_BLOCK_AVG_ROUND_EN
    exp_q.push_back({1'b0, 16'd101});
`else
    exp_q.push_back({1'b0, 16'd100});
`endif
    send(16'd101);
    idle(1);
    send(16'd100);
    send(16'd99);
    send(16'd99);
    exp_q.push_back({1'b0, 16'd99});
    send(16'd99);
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL round_drain: %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_gaps_clear();
    send(16'd10);
    idle(1);
    send(16'd12);
    idle(2);
    send(16'd14);
    exp_q.push_back({1'b0, 16'd13});
    send(16'd16);
    idle(1);
    send(16'd30);
    send(16'd40);
    clear = 1'b1;
    send(16'd50);
    clear = 1'b0;
    ph_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL clear_no_out: out_valid=%b expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clear_busy: busy=%b expected 0", busy); else n_pass++;
    n_checks++; if (ph_out !== 16'd13) $display("FAIL clear_hold: ph_out=%0d expected 13", ph_out); else n_pass++;
    idle(2);
    send(16'd20);
    send(16'd20);
    send(16'd20);
    exp_q.push_back({1'b0, 16'd20});
    send(16'd20);
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL gaps_drain: %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midblock();
    send(16'd1);
    send(16'd2);
    send(16'd3);
    ph_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ph_out !== '0)      $display("FAIL mid_rst_ph_out: got %0d expected 0", ph_out);   else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (warn !== 1'b0)      $display("FAIL mid_rst_warn: got %b expected 0", warn);         else n_pass++;
    n_checks++; if (busy !== 1'b0)      $display("FAIL mid_rst_busy: got %b expected 0", busy);         else n_pass++;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd7);
    send(16'd7);
    send(16'd7);
    exp_q.push_back({1'b0, 16'd7});
    send(16'd7);
    idle(3);
    n_checks++; if (exp_q.size() != 0) $display("FAIL mid_rst_drain: %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic [w-1:0] s [4];
    logic [w-1:0] base;
    for (int b = 0; b < 30; b++) begin
      base = w'($urandom_range(0, 65535));
      for (int i = 0; i < 4; i++) begin
        if (b % 2 == 0) s[i] = base + w'($urandom_range(0, 2000)) - w'(1000);
        else            s[i] = w'($urandom_range(0, 65535));
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if (i == 3) exp_q.push_back(model(s[0], s[1], s[2], s[3]));
        send(s[i]);
      end
    end
    wait_drain();
    n_checks++; if (exp_q.size() != 0) $display("FAIL random_drain: %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_rounding();
    test_gaps_clear();
    test_reset_midblock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
